// File: rtl/accu_datapath_seq_pkg.sv
// -----------------------------------------------------------------------------
// accu_datapath_seq_pkg
// Shared definitions for the accumulator datapath: the sequencer state
// encoding, the opcode map and a helper that classifies opcodes as legal.
// Imported by accu_datapath_seq and accu_mul_seq.
// -----------------------------------------------------------------------------
package accu_datapath_seq_pkg;

   // Sequencer states. IDLE accepts commands, MUL waits on the shift-add
   // multiplier, DONE is the single cycle in which a multiply result is shown.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Opcode map. Codes 12..15 are deliberately left out; they are illegal and
   // complete in one cycle with a zero result and no write-back.
   typedef enum logic [3:0] {
      OP_PASSA = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_LOAD  = 4'd3,
      OP_NAND  = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_SHL   = 4'd8,
      OP_SHR   = 4'd9,
      OP_MUL   = 4'd10,
      OP_CLR   = 4'd11
   } op_e;

   // True for opcodes that have a defined meaning (0..11).
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_CLR);
   endfunction

endpackage

// File: rtl/accu_mul_seq.sv
// -----------------------------------------------------------------------------
// accu_mul_seq
// Sequential shift-add unsigned multiplier. Operands are captured on the
// start cycle and the product is built over WIDTH iterations, the first of
// which happens on the start edge itself. done_o is high for exactly one
// cycle once the full 2*WIDTH-bit product is available on prod_o.
//
// Ports
//   clk      in   1          rising-edge clock
//   reset_n  in   1          asynchronous active-low reset, aborts any run
//   start_i  in   1          launch a multiply with a_i/b_i this cycle
//   a_i      in   WIDTH      multiplicand
//   b_i      in   WIDTH      multiplier
//   done_o   out  1          product on prod_o is final (one-cycle pulse)
//   prod_o   out  2*WIDTH    product register
// -----------------------------------------------------------------------------
module accu_mul_seq
   import accu_datapath_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcandQ, mcandD;
   logic [WIDTH-1:0]   mplierQ, mplierD;
   logic [2*WIDTH-1:0] prodQ, prodD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic               activeQ, activeD;

   logic [2*WIDTH-1:0] srcMcand;
   logic [WIDTH-1:0]   srcMplier;
   logic [2*WIDTH-1:0] srcProd;

   // One shift-add step. On start the step is applied to the fresh operands
   // with a cleared product, so the final partial product lands one edge
   // earlier and the top sees done_o in the last busy cycle. cntQ counts the
   // steps still outstanding; done is raised when it reaches zero and the
   // run is dropped on the following edge.
   always_comb begin
      mcandD  = mcandQ;
      mplierD = mplierQ;
      prodD   = prodQ;
      cntD    = cntQ;
      activeD = activeQ;

      if (start_i) begin
         srcMcand  = {{WIDTH{1'b0}}, a_i};
         srcMplier = b_i;
         srcProd   = '0;
      end else begin
         srcMcand  = mcandQ;
         srcMplier = mplierQ;
         srcProd   = prodQ;
      end

      if (start_i) begin
         prodD   = srcMplier[0] ? (srcProd + srcMcand) : srcProd;
         mcandD  = srcMcand << 1;
         mplierD = srcMplier >> 1;
         cntD    = CNT_W'(WIDTH - 1);
         activeD = 1'b1;
      end else if (activeQ) begin
         if (cntQ != '0) begin
            prodD   = srcMplier[0] ? (srcProd + srcMcand) : srcProd;
            mcandD  = srcMcand << 1;
            mplierD = srcMplier >> 1;
            cntD    = cntQ - 1'b1;
         end else begin
            activeD = 1'b0;
         end
      end
   end

   // Iteration state; reset abandons any multiply in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcandQ  <= '0;
         mplierQ <= '0;
         prodQ   <= '0;
         cntQ    <= '0;
         activeQ <= 1'b0;
      end else begin
         mcandQ  <= mcandD;
         mplierQ <= mplierD;
         prodQ   <= prodD;
         cntQ    <= cntD;
         activeQ <= activeD;
      end
   end

   // Product is complete once every step has been applied.
   assign done_o = activeQ && (cntQ == '0);
   assign prod_o = prodQ;

endmodule

// File: rtl/accu_datapath_seq.sv
// -----------------------------------------------------------------------------
// accu_datapath_seq
// Accumulator datapath with NUM_ACC accumulators, a valid/ready command port,
// single-cycle ALU ops, a multi-cycle shift-add multiply, registered C/Z
// flags and a tri-state result bus driver.
//
// Ports
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous active-low reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       command accepted this cycle if cmd_valid
//   cmd_op     in   4       opcode
//   cmd_acc    in   SEL_W   accumulator used as operand A and write target
//   cmd_wr     in   1       write result back to cmd_acc
//   cmd_data   in   WIDTH   operand B
//   res_valid  out  1       one-cycle pulse when a command completes
//   res_data   out  WIDTH   result of last completed command
//   flag_c     out  1       carry/borrow/overflow of last completed command
//   flag_z     out  1       zero flag of last completed command
//   busy       out  1       multiply in progress
//   out_en     in   1       bus output enable
//   bus_out    out  WIDTH   res_data when out_en, else high-Z
// -----------------------------------------------------------------------------
module accu_datapath_seq
   import accu_datapath_seq_pkg::*;
#(
   parameter  int WIDTH   = 4,
   parameter  int NUM_ACC = 2,
   localparam int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [SEL_W-1:0] cmd_acc,
   input  logic             cmd_wr,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             flag_c,
   output logic             flag_z,
   output logic             busy,
   input  logic             out_en,
   output tri   [WIDTH-1:0] bus_out
);

   state_e             stateQ, stateD;
   logic [WIDTH-1:0]   accQ [NUM_ACC];
   logic [WIDTH-1:0]   resDataQ, resDataD;
   logic               flagCQ, flagCD;
   logic               flagZQ, flagZD;
   logic               resValidQ, resValidD;
   logic [SEL_W-1:0]   mulSelQ, mulSelD;
   logic               mulWrQ, mulWrD;

   logic               accept;
   logic               accLegal;
   logic               opLegal;
   logic [WIDTH-1:0]   opA;
   logic [WIDTH-1:0]   aluR;
   logic               aluC;
   logic [WIDTH-1:0]   cmpR;
   logic               accWe;
   logic [SEL_W-1:0]   accWsel;
   logic [WIDTH-1:0]   accWdata;
   logic               mulStart;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProd;

   // When NUM_ACC fills the select field every code is a real accumulator,
   // so the range check only exists for non-power-of-two counts.
   generate
      if ((1 << SEL_W) == NUM_ACC) begin : g_sel_full
         assign accLegal = 1'b1;
      end else begin : g_sel_part
         assign accLegal = (int'(cmd_acc) < NUM_ACC);
      end
   endgenerate

   assign cmd_ready = (stateQ == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign opLegal   = op_is_legal(cmd_op) && accLegal;
   assign opA       = accLegal ? accQ[cmd_acc] : '0;

   // Single-cycle ALU. Operand A is read straight from the accumulator array,
   // so a command accepted right after a write sees the new value. MUL, CLR
   // and illegal codes fall to the zero default; MUL is produced by the
   // multiplier instead.
   always_comb begin
      aluR = '0;
      aluC = 1'b0;
      case (cmd_op)
         OP_PASSA: aluR = opA;
         OP_ADD:   {aluC, aluR} = {1'b0, opA} + {1'b0, cmd_data};
         OP_SUB: begin
            aluR = opA - cmd_data;
            aluC = (opA < cmd_data);
         end
         OP_LOAD:  aluR = cmd_data;
         OP_NAND:  aluR = ~(opA & cmd_data);
         OP_AND:   aluR = opA & cmd_data;
         OP_OR:    aluR = opA | cmd_data;
         OP_XOR:   aluR = opA ^ cmd_data;
         OP_SHL: begin
            aluR = {opA[WIDTH-2:0], 1'b0};
            aluC = opA[WIDTH-1];
         end
         OP_SHR: begin
            aluR = {1'b0, opA[WIDTH-1:1]};
            aluC = opA[0];
         end
         default: begin
            aluR = '0;
            aluC = 1'b0;
         end
      endcase
   end

   // Sequencer next-state and completion logic. Single-cycle ops complete on
   // the accept edge. A legal MUL parks the FSM in MUL while the multiplier
   // runs; its target and write enable are remembered here because the
   // command fields are only valid at accept. The result is registered on the
   // edge that enters DONE so res_valid is visible during DONE.
   always_comb begin
      stateD    = stateQ;
      resDataD  = resDataQ;
      flagCD    = flagCQ;
      flagZD    = flagZQ;
      resValidD = 1'b0;
      mulSelD   = mulSelQ;
      mulWrD    = mulWrQ;
      mulStart  = 1'b0;
      accWe     = 1'b0;
      accWsel   = '0;
      accWdata  = '0;
      cmpR      = '0;

      case (stateQ)
         ST_IDLE: begin
            if (accept) begin
               if ((cmd_op == OP_MUL) && opLegal) begin
                  mulStart = 1'b1;
                  mulSelD  = cmd_acc;
                  mulWrD   = cmd_wr;
                  stateD   = ST_MUL;
               end else begin
                  cmpR      = opLegal ? aluR : '0;
                  resDataD  = cmpR;
                  flagCD    = opLegal ? aluC : 1'b0;
                  flagZD    = (cmpR == '0);
                  resValidD = 1'b1;
                  accWe     = opLegal && cmd_wr;
                  accWsel   = cmd_acc;
                  accWdata  = cmpR;
               end
            end
         end
         ST_MUL: begin
            if (mulDone) begin
               cmpR      = mulProd[WIDTH-1:0];
               resDataD  = cmpR;
               flagCD    = |mulProd[2*WIDTH-1:WIDTH];
               flagZD    = (cmpR == '0);
               resValidD = 1'b1;
               accWe     = mulWrQ;
               accWsel   = mulSelQ;
               accWdata  = cmpR;
               stateD    = ST_DONE;
            end
         end
         ST_DONE: begin
            stateD = ST_IDLE;
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, result and flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ    <= ST_IDLE;
         resDataQ  <= '0;
         flagCQ    <= 1'b0;
         flagZQ    <= 1'b0;
         resValidQ <= 1'b0;
         mulSelQ   <= '0;
         mulWrQ    <= 1'b0;
      end else begin
         stateQ    <= stateD;
         resDataQ  <= resDataD;
         flagCQ    <= flagCD;
         flagZQ    <= flagZD;
         resValidQ <= resValidD;
         mulSelQ   <= mulSelD;
         mulWrQ    <= mulWrD;
      end
   end

   // Accumulator array. Only the selected entry is written; accWsel is always
   // a real accumulator whenever accWe is set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            accQ[i] <= '0;
         end
      end else if (accWe) begin
         accQ[accWsel] <= accWdata;
      end
   end

   // Multiplier captures opA and cmd_data on the accept cycle, so later
   // changes on the command port cannot disturb a running multiply.
   accu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (mulStart),
      .a_i     (opA),
      .b_i     (cmd_data),
      .done_o  (mulDone),
      .prod_o  (mulProd)
   );

   assign res_valid = resValidQ;
   assign res_data  = resDataQ;
   assign flag_c    = flagCQ;
   assign flag_z    = flagZQ;
   assign busy      = (stateQ == ST_MUL);

   // Bus driver follows out_en alone, regardless of what the FSM is doing.
   assign bus_out = out_en ? resDataQ : {WIDTH{1'bz}};

endmodule

// File: tb/tb_accu_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_accu_datapath_seq
// Self-checking bench for accu_datapath_seq (WIDTH=4, NUM_ACC=2). Expected
// results come from an arithmetic model of the accumulators kept in the bench.
// -----------------------------------------------------------------------------
module tb_accu_datapath_seq;

   localparam int OP_PASSA = 0;
   localparam int OP_ADD   = 1;
   localparam int OP_SUB   = 2;
   localparam int OP_LOAD  = 3;
   localparam int OP_SHL   = 8;
   localparam int OP_SHR   = 9;
   localparam int OP_MUL   = 10;
   localparam int OP_CLR   = 11;

   logic       clk;
   logic       reset_n;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic       cmd_acc;
   logic       cmd_wr;
   logic [3:0] cmd_data;
   logic       out_en;
   wire        cmd_ready;
   wire        res_valid;
   wire  [3:0] res_data;
   wire        flag_c;
   wire        flag_z;
   wire        busy;
   wire  [3:0] bus_out;

   pullup (bus_out[0]);
   pullup (bus_out[1]);
   pullup (bus_out[2]);
   pullup (bus_out[3]);

   int checks;
   int failures;
   int modelAcc [2];

   accu_datapath_seq #(
      .WIDTH   (4),
      .NUM_ACC (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_acc   (cmd_acc),
      .cmd_wr    (cmd_wr),
      .cmd_data  (cmd_data),
      .res_valid (res_valid),
      .res_data  (res_data),
      .flag_c    (flag_c),
      .flag_z    (flag_z),
      .busy      (busy),
      .out_en    (out_en),
      .bus_out   (bus_out)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Arithmetic reference: computes result and carry from the opcode table
   // using integer arithmetic and updates the model accumulators.
   function automatic void modelOp(input int op, input int sel, input int wr,
                                   input int b, output int r, output int c);
      int a;
      a = modelAcc[sel];
      r = 0;
      c = 0;
      case (op)
         0:  r = a;
         1:  begin r = (a + b) % 16; c = ((a + b) > 15) ? 1 : 0; end
         2:  begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
         3:  r = b;
         4:  r = 15 - (a & b);
         5:  r = a & b;
         6:  r = a | b;
         7:  r = a ^ b;
         8:  begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
         9:  begin r = a / 2; c = a % 2; end
         10: begin r = (a * b) % 16; c = ((a * b) > 15) ? 1 : 0; end
         default: begin r = 0; c = 0; end
      endcase
      if (wr != 0 && op <= 11) modelAcc[sel] = r;
   endfunction

   // Drives one command, optionally keeps a different command valid while
   // the first is in flight, and waits (bounded) for res_valid.
   task automatic applyStimulus(input int op, input int sel, input int wr,
                                input int data, input bit hold,
                                output int obsR, output int obsC, output int obsZ,
                                output int lat, output int busyCyc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_op    = 4'(op);
      cmd_acc   = 1'(sel);
      cmd_wr    = 1'(wr);
      cmd_data  = 4'(data);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         cmd_op   = 4'(OP_LOAD);
         cmd_acc  = 1'b1;
         cmd_wr   = 1'b1;
         cmd_data = 4'd15;
      end else begin
         cmd_valid = 1'b0;
      end
      lat     = 0;
      busyCyc = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busyCyc++;
      end while (!res_valid && lat < 40);
      obsR      = int'(res_data);
      obsC      = int'(flag_c);
      obsZ      = int'(flag_z);
      cmd_valid = 1'b0;
   endtask

   // Asynchronous reset in the middle of activity clears everything at once.
   task automatic test_reset();
      int r, c, oR, oC, oZ, lat, bc;
      modelOp(OP_LOAD, 0, 1, 9, r, c);
      applyStimulus(OP_LOAD, 0, 1, 9, 1'b0, oR, oC, oZ, lat, bc);
      modelOp(OP_LOAD, 1, 1, 6, r, c);
      applyStimulus(OP_LOAD, 1, 1, 6, 1'b0, oR, oC, oZ, lat, bc);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (res_data !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_res_data got=%0d exp=0", res_data);
      end
      checks++;
      if ({flag_c, flag_z, res_valid, busy} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_flags got c=%b z=%b v=%b busy=%b exp=0000",
                  flag_c, flag_z, res_valid, busy);
      end
      modelAcc[0] = 0;
      modelAcc[1] = 0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_ready got=%b exp=1", cmd_ready);
      end
      for (int s = 0; s < 2; s++) begin
         modelOp(OP_PASSA, s, 0, 0, r, c);
         applyStimulus(OP_PASSA, s, 0, 0, 1'b0, oR, oC, oZ, lat, bc);
         checks++;
         if (oR !== r || oZ !== 1) begin
            failures++;
            $display("[TB] FAIL reset_acc%0d got r=%0d z=%0d exp r=%0d z=1", s, oR, oZ, r);
         end
      end
   endtask

   // Fixed sequence of single-cycle ops on both accumulators.
   task automatic test_directed();
      int ops  [6] = '{OP_LOAD, OP_ADD, OP_SUB, OP_LOAD, OP_SUB, OP_PASSA};
      int sels [6] = '{0, 0, 0, 1, 1, 0};
      int wrs  [6] = '{1, 1, 1, 1, 1, 0};
      int dats [6] = '{9, 8, 1, 3, 5, 0};
      int r, c, oR, oC, oZ, lat, bc;
      for (int i = 0; i < 6; i++) begin
         modelOp(ops[i], sels[i], wrs[i], dats[i], r, c);
         applyStimulus(ops[i], sels[i], wrs[i], dats[i], 1'b0, oR, oC, oZ, lat, bc);
         checks++;
         if (oR !== r || oC !== c || oZ !== ((r == 0) ? 1 : 0) || lat !== 1) begin
            failures++;
            $display("[TB] FAIL directed_%0d got r=%0d c=%0d z=%0d lat=%0d exp r=%0d c=%0d lat=1",
                     i, oR, oC, oZ, lat, r, c);
         end
      end
   endtask

   // Multiply timing, result, and a held command that must not be taken.
   task automatic test_mul();
      int r, c, oR, oC, oZ, lat, bc;
      modelOp(OP_LOAD, 0, 1, 7, r, c);
      applyStimulus(OP_LOAD, 0, 1, 7, 1'b0, oR, oC, oZ, lat, bc);
      modelOp(OP_MUL, 0, 1, 3, r, c);
      applyStimulus(OP_MUL, 0, 1, 3, 1'b1, oR, oC, oZ, lat, bc);
      checks++;
      if (oR !== r || oC !== c || oZ !== ((r == 0) ? 1 : 0)) begin
         failures++;
         $display("[TB] FAIL mul_result got r=%0d c=%0d z=%0d exp r=%0d c=%0d", oR, oC, oZ, r, c);
      end
      checks++;
      if (lat !== 5 || bc !== 4) begin
         failures++;
         $display("[TB] FAIL mul_timing got lat=%0d busy=%0d exp lat=5 busy=4", lat, bc);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mul_pulse got=%b exp=0", res_valid);
      end
      for (int s = 1; s >= 0; s--) begin
         modelOp(OP_PASSA, s, 0, 0, r, c);
         applyStimulus(OP_PASSA, s, 0, 0, 1'b0, oR, oC, oZ, lat, bc);
         checks++;
         if (oR !== r) begin
            failures++;
            $display("[TB] FAIL mul_acc%0d got=%0d exp=%0d", s, oR, r);
         end
      end
   endtask

   // Shifts at their carry boundaries and an illegal opcode with wr set.
   task automatic test_shift_illegal();
      int ops  [6] = '{OP_LOAD, OP_SHL, OP_LOAD, OP_SHR, 13, OP_PASSA};
      int sels [6] = '{0, 0, 1, 1, 0, 0};
      int wrs  [6] = '{1, 1, 1, 1, 1, 0};
      int dats [6] = '{9, 0, 1, 0, 7, 0};
      int r, c, oR, oC, oZ, lat, bc;
      for (int i = 0; i < 6; i++) begin
         modelOp(ops[i], sels[i], wrs[i], dats[i], r, c);
         applyStimulus(ops[i], sels[i], wrs[i], dats[i], 1'b0, oR, oC, oZ, lat, bc);
         checks++;
         if (oR !== r || oC !== c || oZ !== ((r == 0) ? 1 : 0) || lat !== 1) begin
            failures++;
            $display("[TB] FAIL shift_illegal_%0d got r=%0d c=%0d z=%0d lat=%0d exp r=%0d c=%0d",
                     i, oR, oC, oZ, lat, r, c);
         end
      end
   endtask

   // Tri-state driver: released bus floats to the pull-ups.
   task automatic test_bus();
      int r, c, oR, oC, oZ, lat, bc;
      modelOp(OP_CLR, 0, 0, 0, r, c);
      applyStimulus(OP_CLR, 0, 0, 0, 1'b0, oR, oC, oZ, lat, bc);
      out_en = 1'b0;
      #1;
      checks++;
      if (bus_out !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL bus_off_zero got=%b exp=1111", bus_out);
      end
      modelOp(OP_LOAD, 1, 0, 6, r, c);
      applyStimulus(OP_LOAD, 1, 0, 6, 1'b0, oR, oC, oZ, lat, bc);
      out_en = 1'b1;
      #1;
      checks++;
      if (bus_out !== 4'(r)) begin
         failures++;
         $display("[TB] FAIL bus_on got=%b exp=%0d", bus_out, r);
      end
      out_en = 1'b0;
      #1;
      checks++;
      if (bus_out !== 4'b1111) begin
         failures++;
         $display("[TB] FAIL bus_off got=%b exp=1111", bus_out);
      end
   endtask

   // One single-cycle command per clock with no gaps; each reads the
   // accumulator written by the one before it.
   task automatic test_back_to_back();
      int op, sel, wr, dat, r, c, guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 24; i++) begin
         do op = int'($urandom_range(0, 15)); while (op == OP_MUL);
         sel = int'($urandom_range(0, 1));
         wr  = (i % 4 == 3) ? 0 : 1;
         dat = int'($urandom_range(0, 15));
         cmd_op    = 4'(op);
         cmd_acc   = 1'(sel);
         cmd_wr    = 1'(wr);
         cmd_data  = 4'(dat);
         cmd_valid = 1'b1;
         modelOp(op, sel, wr, dat, r, c);
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== 4'(r) || flag_c !== 1'(c) ||
             flag_z !== ((r == 0) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("[TB] FAIL b2b_%0d op=%0d got v=%b r=%0d c=%b z=%b exp r=%0d c=%0d",
                     i, op, res_valid, res_data, flag_c, flag_z, r, c);
         end
      end
      cmd_valid = 1'b0;
   endtask

   // Random mix including multiplies, checked for value and latency.
   task automatic test_random();
      int op, sel, wr, dat, r, c, oR, oC, oZ, lat, bc, expLat;
      for (int i = 0; i < 30; i++) begin
         op  = (i % 3 == 0) ? OP_MUL : int'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 1));
         wr  = int'($urandom_range(0, 1));
         dat = int'($urandom_range(0, 15));
         expLat = (op == OP_MUL) ? 5 : 1;
         modelOp(op, sel, wr, dat, r, c);
         applyStimulus(op, sel, wr, dat, 1'b0, oR, oC, oZ, lat, bc);
         checks++;
         if (oR !== r || oC !== c || oZ !== ((r == 0) ? 1 : 0) || lat !== expLat) begin
            failures++;
            $display("[TB] FAIL rand_%0d op=%0d got r=%0d c=%0d z=%0d lat=%0d exp r=%0d c=%0d lat=%0d",
                     i, op, oR, oC, oZ, lat, r, c, expLat);
         end
      end
   endtask

   // Reset while a multiply is running aborts it with no late completion.
   task automatic test_reset_during_mul();
      int r, c, oR, oC, oZ, lat, bc, seen, guard;
      modelOp(OP_LOAD, 0, 1, 11, r, c);
      applyStimulus(OP_LOAD, 0, 1, 11, 1'b0, oR, oC, oZ, lat, bc);
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cmd_op    = 4'(OP_MUL);
      cmd_acc   = 1'b0;
      cmd_wr    = 1'b1;
      cmd_data  = 4'd13;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rstmul_busy_before got=%b exp=1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 4'd0) begin
         failures++;
         $display("[TB] FAIL rstmul_clear got busy=%b v=%b r=%0d exp 0 0 0", busy, res_valid, res_data);
      end
      modelAcc[0] = 0;
      modelAcc[1] = 0;
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (res_valid || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("[TB] FAIL rstmul_no_complete got=%0d exp=0", seen);
      end
      modelOp(OP_PASSA, 0, 0, 0, r, c);
      applyStimulus(OP_PASSA, 0, 0, 0, 1'b0, oR, oC, oZ, lat, bc);
      checks++;
      if (oR !== r) begin
         failures++;
         $display("[TB] FAIL rstmul_acc0 got=%0d exp=%0d", oR, r);
      end
   endtask

   // Test sequence.
   initial begin
      checks    = 0;
      failures  = 0;
      modelAcc  = '{0, 0};
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_acc   = 1'b0;
      cmd_wr    = 1'b0;
      cmd_data  = 4'd0;
      out_en    = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      $display("[TB] starting");
      test_reset();
      test_directed();
      test_mul();
      test_shift_illegal();
      test_bus();
      test_back_to_back();
      test_random();
      test_reset_during_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
